// File: rtl/melody_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : melody_sequencer                                           |
// | Description : Plays a 16-entry table of {note, rest, duration} steps to   |
// |               a tone generator, with optional silent gap between entries |
// |               and optional looping.                                      |
// | Ports       : clk, rst_n          - clock, async active-low reset        |
// |               wr_en/wr_addr/wr_note/wr_rest/wr_dur - table write port    |
// |               start, stop         - playback control pulses              |
// |               loop, last_idx      - sequence shape, sampled at start     |
// |               note, hush          - registered tone generator drive      |
// |               busy, step_idx      - playback status                      |
// |               done                - end-of-sequence pulse (non-looping)  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module melody_sequencer #(
  parameter int TICK_DIV  = 500000,
  parameter int GAP_TICKS = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [3:0] wr_note,
  input  logic       wr_rest,
  input  logic [5:0] wr_dur,
  input  logic       start,
  input  logic       stop,
  input  logic       loop,
  input  logic [3:0] last_idx,
  output logic [3:0] note,
  output logic       hush,
  output logic       busy,
  output logic [3:0] step_idx,
  output logic       done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PLAY = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Prescaler counts clk cycles within one tick; tick counter counts ticks
  // within an entry. The tick counter is wide enough for a 63-tick entry and
  // for the gap length, whichever is larger.
  localparam int PW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GAP_TW = $clog2(GAP_TICKS + 1);
  localparam int TW     = (GAP_TW > 6) ? GAP_TW : 6;

  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] GAP_LAST = TW'(GAP_TICKS - 1);

  // Entry layout: [10:7] note, [6] rest, [5:0] duration in ticks
  logic [10:0]   mem [16];

  logic [1:0]    state;
  logic          loop_r;
  logic [3:0]    last_r;
  logic [PW-1:0] pre_cnt;
  logic [TW-1:0] tick_cnt;

  logic [5:0]    cur_dur;
  logic          pre_wrap;
  logic          play_end;
  logic          gap_end;
  logic          entry_end;
  logic          at_last;
  logic [3:0]    nxt_idx;

  assign busy = (state == ST_PLAY) || (state == ST_GAP);
  assign done = (state == ST_DONE);

  // Table writes are locked out during playback so the playing sequence
  // cannot change underneath the counters.
  always_ff @(posedge clk) begin
    if (wr_en && !busy) begin
      mem[wr_addr] <= {wr_note, wr_rest, wr_dur};
    end
  end

  always_comb begin
    cur_dur   = mem[step_idx][5:0];
    if (cur_dur == 6'd0) begin
      cur_dur = 6'd1;
    end
    pre_wrap  = (pre_cnt == PRE_LAST);
    play_end  = pre_wrap && (tick_cnt == TW'(cur_dur - 6'd1));
    gap_end   = pre_wrap && (tick_cnt == GAP_LAST);
    // With no gap configured, PLAY advances straight to the next entry.
    entry_end = ((state == ST_PLAY) && play_end && (GAP_TICKS == 0)) ||
                ((state == ST_GAP) && gap_end);
    at_last   = (step_idx == last_r);
    nxt_idx   = at_last ? 4'd0 : (step_idx + 4'd1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      note     <= 4'd0;
      hush     <= 1'b1;
      step_idx <= 4'd0;
      loop_r   <= 1'b0;
      last_r   <= 4'd0;
      pre_cnt  <= '0;
      tick_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          hush <= 1'b1;
          if (start && !stop) begin
            loop_r   <= loop;
            last_r   <= last_idx;
            step_idx <= 4'd0;
            note     <= mem[0][10:7];
            hush     <= mem[0][6];
            pre_cnt  <= '0;
            tick_cnt <= '0;
            state    <= ST_PLAY;
          end
        end

        ST_PLAY, ST_GAP: begin
          if (pre_wrap) begin
            pre_cnt  <= '0;
            tick_cnt <= tick_cnt + TW'(1);
          end else begin
            pre_cnt  <= pre_cnt + PW'(1);
          end

          if (stop) begin
            state    <= ST_IDLE;
            hush     <= 1'b1;
            pre_cnt  <= '0;
            tick_cnt <= '0;
          end else if ((state == ST_PLAY) && play_end && (GAP_TICKS > 0)) begin
            state    <= ST_GAP;
            hush     <= 1'b1;
            pre_cnt  <= '0;
            tick_cnt <= '0;
          end else if (entry_end) begin
            pre_cnt  <= '0;
            tick_cnt <= '0;
            if (!at_last || loop_r) begin
              step_idx <= nxt_idx;
              note     <= mem[nxt_idx][10:7];
              hush     <= mem[nxt_idx][6];
              state    <= ST_PLAY;
            end else begin
              hush     <= 1'b1;
              state    <= ST_DONE;
            end
          end
        end

        ST_DONE: begin
          hush  <= 1'b1;
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_melody_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_melody_sequencer                                        |
// | Description : Scoreboard bench for melody_sequencer (TICK_DIV=4,         |
// |               GAP_TICKS=1). Stimulus pushes per-cycle expected outputs;  |
// |               a negedge monitor pops and compares them.                  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_melody_sequencer;

  typedef struct packed {
    logic [3:0] note;
    logic       hush;
    logic       busy;
    logic       done;
    logic [3:0] step;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [3:0] wr_note;
  logic       wr_rest;
  logic [5:0] wr_dur;
  logic       start;
  logic       stop;
  logic       loop;
  logic [3:0] last_idx;
  logic [3:0] note;
  logic       hush;
  logic       busy;
  logic [3:0] step_idx;
  logic       done;

  int   errors = 0;
  int   checks = 0;
  int   rec_no = 0;
  rec_t q[$];

  melody_sequencer #(.TICK_DIV(4), .GAP_TICKS(1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_note  (wr_note),
    .wr_rest  (wr_rest),
    .wr_dur   (wr_dur),
    .start    (start),
    .stop     (stop),
    .loop     (loop),
    .last_idx (last_idx),
    .note     (note),
    .hush     (hush),
    .busy     (busy),
    .step_idx (step_idx),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input rec_t act, input rec_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got note=%0d hush=%0d busy=%0d done=%0d step=%0d, expected note=%0d hush=%0d busy=%0d done=%0d step=%0d",
               name, act.note, act.hush, act.busy, act.done, act.step,
               exp.note, exp.hush, exp.busy, exp.done, exp.step);
    end
  endtask

  // Monitor: outputs are presented every cycle, so each queued record is
  // compared against the DUT at the following falling edge.
  always @(negedge clk) begin
    rec_t exp;
    rec_t act;
    if (q.size() > 0) begin
      exp = q.pop_front();
      act = {note, hush, busy, done, step_idx};
      check($sformatf("rec%0d", rec_no), act, exp);
      rec_no++;
    end
  end

  task automatic push_n(input int n, input logic [3:0] nt, input logic h,
                        input logic b, input logic d, input logic [3:0] s);
    rec_t r;
    r = {nt, h, b, d, s};
    for (int i = 0; i < n; i++) q.push_back(r);
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (q.size() == 0) break;
      @(posedge clk);
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d records pending, expected 0", q.size());
      q.delete();
    end
    #1;
  endtask

  task automatic write_entry(input logic [3:0] a, input logic [3:0] nt,
                             input logic r, input logic [5:0] d);
    wr_en = 1'b1; wr_addr = a; wr_note = nt; wr_rest = r; wr_dur = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic pulse_start(input logic lp, input logic [3:0] li, input logic also_stop);
    loop = lp; last_idx = li; start = 1'b1; stop = also_stop;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
  endtask

  initial begin
    rec_t act;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = 4'd0; wr_note = 4'd0; wr_rest = 1'b0;
    wr_dur = 6'd0; start = 1'b0; stop = 1'b0; loop = 1'b0; last_idx = 4'd0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    push_n(3, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0);
    drain();

    // Two-entry non-looping sequence with gaps and done pulse
    write_entry(4'd0, 4'd5, 1'b0, 6'd2);
    write_entry(4'd1, 4'd9, 1'b0, 6'd1);
    push_n(1, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0);
    push_n(8, 4'd5, 1'b0, 1'b1, 1'b0, 4'd0);
    push_n(4, 4'd5, 1'b1, 1'b1, 1'b0, 4'd0);
    push_n(4, 4'd9, 1'b0, 1'b1, 1'b0, 4'd1);
    push_n(4, 4'd9, 1'b1, 1'b1, 1'b0, 4'd1);
    push_n(1, 4'd9, 1'b1, 1'b0, 1'b1, 4'd1);
    push_n(1, 4'd9, 1'b1, 1'b0, 1'b0, 4'd1);
    pulse_start(1'b0, 4'd1, 1'b0);
    drain();

    // Same run, with a write to entry 0 and a restart attempt during the gap
    push_n(1, 4'd9, 1'b1, 1'b0, 1'b0, 4'd1);
    push_n(8, 4'd5, 1'b0, 1'b1, 1'b0, 4'd0);
    push_n(4, 4'd5, 1'b1, 1'b1, 1'b0, 4'd0);
    push_n(4, 4'd9, 1'b0, 1'b1, 1'b0, 4'd1);
    push_n(4, 4'd9, 1'b1, 1'b1, 1'b0, 4'd1);
    push_n(1, 4'd9, 1'b1, 1'b0, 1'b1, 4'd1);
    push_n(1, 4'd9, 1'b1, 1'b0, 1'b0, 4'd1);
    pulse_start(1'b0, 4'd1, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    start = 1'b1; loop = 1'b1; last_idx = 4'd0;
    wr_en = 1'b1; wr_addr = 4'd0; wr_note = 4'd7; wr_rest = 1'b0; wr_dur = 6'd2;
    @(posedge clk); #1;
    start = 1'b0; wr_en = 1'b0; loop = 1'b0; last_idx = 4'd1;
    drain();

    // Looping replay (entry 0 must still be note 5), then stop mid-play
    push_n(1, 4'd9, 1'b1, 1'b0, 1'b0, 4'd1);
    push_n(8, 4'd5, 1'b0, 1'b1, 1'b0, 4'd0);
    push_n(4, 4'd5, 1'b1, 1'b1, 1'b0, 4'd0);
    push_n(4, 4'd9, 1'b0, 1'b1, 1'b0, 4'd1);
    push_n(4, 4'd9, 1'b1, 1'b1, 1'b0, 4'd1);
    push_n(3, 4'd5, 1'b0, 1'b1, 1'b0, 4'd0);
    push_n(2, 4'd5, 1'b1, 1'b0, 1'b0, 4'd0);
    pulse_start(1'b1, 4'd1, 1'b0);
    repeat (22) @(posedge clk);
    #1 stop = 1'b1;
    @(posedge clk); #1 stop = 1'b0;
    drain();

    // Single rest entry with zero duration
    write_entry(4'd0, 4'd3, 1'b1, 6'd0);
    push_n(1, 4'd5, 1'b1, 1'b0, 1'b0, 4'd0);
    push_n(8, 4'd3, 1'b1, 1'b1, 1'b0, 4'd0);
    push_n(1, 4'd3, 1'b1, 1'b0, 1'b1, 4'd0);
    push_n(1, 4'd3, 1'b1, 1'b0, 1'b0, 4'd0);
    pulse_start(1'b0, 4'd0, 1'b0);
    drain();

    // start and stop together in IDLE
    push_n(4, 4'd3, 1'b1, 1'b0, 1'b0, 4'd0);
    pulse_start(1'b0, 4'd0, 1'b1);
    drain();

    // Asynchronous reset in the middle of PLAY
    write_entry(4'd0, 4'd6, 1'b0, 6'd3);
    push_n(1, 4'd3, 1'b1, 1'b0, 1'b0, 4'd0);
    push_n(4, 4'd6, 1'b0, 1'b1, 1'b0, 4'd0);
    pulse_start(1'b0, 4'd0, 1'b0);
    drain();
    rst_n = 1'b0;
    #1;
    act = {note, hush, busy, done, step_idx};
    check("async_reset", act, {4'd0, 1'b1, 1'b0, 1'b0, 4'd0});
    @(posedge clk); #1;
    rst_n = 1'b1;
    push_n(3, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
